led_scan_ctrl: RTL

Sequencer that drives the 4-bit index and enable inputs of the LED 4x16 decoder, producing a walking one-hot LED pattern.
- Pattern modes: hold, count up, count down, bounce.
- Step rate is set by an internal prescaler.
- Sits between board switches/buttons and the decoder; the decoder itself stays purely combinational downstream.

---
 rtl/led_scan_ctrl_pkg.sv | 34 +++
 rtl/led_scan_ctrl_tick_gen.sv | 32 +++
 rtl/led_scan_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/led_scan_ctrl_pkg.sv
// led_scan_ctrl_pkg: shared encodings for the LED scan sequencer.
//   mode_e  - pattern mode as presented on the mode input
//   state_e - sequencer FSM states
//   dir_e   - current travel direction (used by bounce)
//   adv_t   - result of one advance step (next index, next dir, wrap event)
package led_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] IDX_MAX = 4'd15;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    dir_e             dir;
    logic             wrap;
  } adv_t;

endpackage

// File: rtl/led_scan_ctrl_tick_gen.sv
// tick_gen: free-running prescaler producing a one-cycle tick every CLK_DIV
// enabled cycles.
//   clk   - system clock
//   rst_n - async active-low reset, counter to 0
//   en    - count enable; tick only asserts while enabled
//   clr   - synchronous clear of the counter (wins over en)
//   tick  - high in the cycle where the count sits at CLK_DIV-1
module tick_gen #(
  parameter int CLK_DIV = 25_000_000,
  parameter int CNT_W   = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt <= '0;
    else if (clr)       cnt <= '0;
    else if (en)        cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
  end

  // With CLK_DIV=1 LAST is 0, so the count never leaves 0 and tick follows en.
  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: sequencer for the 4x16 LED decoder. Walks a one-hot index
// in hold / up / down / bounce patterns at a prescaled step rate.
//   clk    - system clock
//   rst_n  - async active-low reset
//   run    - level, 1 = scanning (ACTIVE), 0 = idle
//   mode   - 00 hold, 01 up, 10 down, 11 bounce
//   step   - pulse, manual advance; only acted on while idle
//   clear  - pulse, return to index 0 / dir up / prescaler 0
//   idx    - registered decoder select
//   dec_en - registered decoder enable (high in ACTIVE)
//   busy   - high in ACTIVE
//   wrap   - one-cycle pulse on wrap-around or bounce reversal
module led_scan_ctrl
  import led_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 25_000_000,
  parameter int CNT_W   = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [1:0]       mode,
  input  logic             step,
  input  logic             clear,
  output logic [IDX_W-1:0] idx,
  output logic             dec_en,
  output logic             busy,
  output logic             wrap
);

  state_e state;
  dir_e   dir;
  logic   tick;
  logic   adv;
  adv_t   nxt;

  // Prescaler is held at 0 while idle so every ACTIVE entry starts a full period.
  tick_gen #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == ST_ACTIVE),
    .clr   (clear || (state == ST_IDLE)),
    .tick  (tick)
  );

  // Advance source: prescaler in ACTIVE, manual step in IDLE.
  assign adv = (state == ST_ACTIVE) ? tick : step;

  always_comb begin
    nxt.idx  = idx;
    nxt.dir  = dir;
    nxt.wrap = 1'b0;
    case (mode_e'(mode))
      MODE_UP: begin
        nxt.idx  = idx + 4'd1;
        nxt.dir  = DIR_UP;
        nxt.wrap = (idx == IDX_MAX);
      end
      MODE_DOWN: begin
        nxt.idx  = idx - 4'd1;
        nxt.dir  = DIR_DOWN;
        nxt.wrap = (idx == '0);
      end
      MODE_BOUNCE: begin
        if (dir == DIR_UP) begin
          if (idx == IDX_MAX) begin
            nxt.idx  = IDX_MAX - 4'd1;
            nxt.dir  = DIR_DOWN;
            nxt.wrap = 1'b1;
          end else begin
            nxt.idx  = idx + 4'd1;
          end
        end else begin
          if (idx == '0) begin
            nxt.idx  = 4'd1;
            nxt.dir  = DIR_UP;
            nxt.wrap = 1'b1;
          end else begin
            nxt.idx  = idx - 4'd1;
          end
        end
      end
      default: ;  // hold: nothing moves
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      idx    <= '0;
      dir    <= DIR_UP;
      dec_en <= 1'b0;
      busy   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clear) begin
        idx <= '0;
        dir <= DIR_UP;
      end else if (adv) begin
        idx  <= nxt.idx;
        dir  <= nxt.dir;
        wrap <= nxt.wrap;
      end
      // The advance above still lands when run drops in a tick cycle.
      case (state)
        ST_IDLE: if (run) begin
          state  <= ST_ACTIVE;
          dec_en <= 1'b1;
          busy   <= 1'b1;
        end
        ST_ACTIVE: if (!run) begin
          state  <= ST_IDLE;
          dec_en <= 1'b0;
          busy   <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
